// File: rtl/filter_pkg.sv
// filter_pkg: types shared by the filter chain and its output sink.
package filter_pkg;

    localparam int DATA_WIDTH = 16;

    // One word of the filter chain output bundle; parity travels with data.
    typedef struct packed {
        logic                  parity;
        logic [DATA_WIDTH-1:0] data;
    } filter_word_t;

    // Pack a data/parity pair into a filter word.
    function automatic filter_word_t make_word(input logic [DATA_WIDTH-1:0] data,
                                               input logic parity);
        filter_word_t w;
        w.parity = parity;
        w.data   = data;
        return w;
    endfunction

endpackage

// File: rtl/filter_sink_mem.sv
// filter_sink_mem: DEPTH-entry register array for filter words.
// One synchronous write port, one asynchronous read port. Contents are not reset.
module filter_sink_mem
    import filter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  filter_word_t             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output filter_word_t             rdata
);

    filter_word_t mem [DEPTH];

    // Write the addressed entry when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Asynchronous read gives the FIFO its fall-through behaviour.
    always_comb begin
        rdata = mem[raddr];
    end

endmodule

// File: rtl/filter_sink.sv
// filter_sink: first-word-fall-through landing FIFO for the filter chain output.
// Words that arrive with no room are dropped and flagged on io_overflow one
// cycle later; the producer is never stalled.
// Optional macro FILTER_SINK_DROP_CNT_EN adds a saturating drop counter port
// io_drop_count (DROP_WIDTH bits).
module filter_sink
    import filter_pkg::*;
#(
    parameter int DATA_WIDTH = filter_pkg::DATA_WIDTH,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
`ifdef FILTER_SINK_DROP_CNT_EN
    ,
    parameter int DROP_WIDTH = 8
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] io_x_data,
    input  logic                  io_x_valid,
    input  logic                  io_x_parity,
    output logic [DATA_WIDTH-1:0] io_y_data,
    output logic                  io_y_valid,
    output logic                  io_y_parity,
    input  logic                  io_y_ready,
    output logic [CNT_WIDTH-1:0]  io_count,
    output logic                  io_overflow
`ifdef FILTER_SINK_DROP_CNT_EN
    ,
    output logic [DROP_WIDTH-1:0] io_drop_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

    logic [AW-1:0]        rd_ptr;
    logic [AW-1:0]        wr_ptr;
    logic [CNT_WIDTH-1:0] count;
    logic                 overflow;
    logic                 empty;
    logic                 full;
    logic                 pop;
    logic                 push;
    logic                 drop;
    filter_word_t         wdata;
    filter_word_t         rdata;

    // Handshake decode; a full FIFO still accepts when the head leaves this cycle.
    always_comb begin
        empty = (count == '0);
        full  = (count == FULL_CNT);
        pop   = ~empty & io_y_ready;
        push  = ~reset & io_x_valid & (~full | pop);
        drop  = ~reset & io_x_valid & ~push;
        wdata = make_word(io_x_data, io_x_parity);
    end

    filter_sink_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wdata),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    // Pointers wrap naturally at DEPTH; occupancy tracks push minus pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_WIDTH'(1);
                2'b01:   count <= count - CNT_WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

    // Registered drop flag: high the cycle after each dropped word.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else begin
            overflow <= drop;
        end
    end

`ifdef FILTER_SINK_DROP_CNT_EN
    logic [DROP_WIDTH-1:0] drop_count;

    // Saturating count of dropped words, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count <= '0;
        end else if (drop && (drop_count != '1)) begin
            drop_count <= drop_count + DROP_WIDTH'(1);
        end
    end

    assign io_drop_count = drop_count;
`endif

    // Head word is forced to zero while empty so stale storage never shows.
    always_comb begin
        io_y_valid  = ~empty;
        io_y_data   = empty ? '0 : rdata.data;
        io_y_parity = empty ? 1'b0 : rdata.parity;
        io_count    = count;
        io_overflow = overflow;
    end

endmodule

// File: tb/tb_filter_sink.sv
// tb_filter_sink: scoreboard bench for filter_sink with a queue reference model.
// Build with FILTER_SINK_DROP_CNT_EN to also check io_drop_count (DROP_WIDTH=4).
module tb_filter_sink;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef FILTER_SINK_DROP_CNT_EN
    localparam int DRW      = 4;
    localparam int DROP_MAX = (1 << DRW) - 1;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] io_x_data = '0;
    logic          io_x_valid = 1'b0;
    logic          io_x_parity = 1'b0;
    logic [DW-1:0] io_y_data;
    logic          io_y_valid;
    logic          io_y_parity;
    logic          io_y_ready = 1'b0;
    logic [CW-1:0] io_count;
    logic          io_overflow;
`ifdef FILTER_SINK_DROP_CNT_EN
    logic [DRW-1:0] io_drop_count;
`endif

    filter_sink #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .CNT_WIDTH  (CW)
`ifdef FILTER_SINK_DROP_CNT_EN
        ,
        .DROP_WIDTH (DRW)
`endif
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .io_x_data   (io_x_data),
        .io_x_valid  (io_x_valid),
        .io_x_parity (io_x_parity),
        .io_y_data   (io_y_data),
        .io_y_valid  (io_y_valid),
        .io_y_parity (io_y_parity),
        .io_y_ready  (io_y_ready),
        .io_count    (io_count),
        .io_overflow (io_overflow)
`ifdef FILTER_SINK_DROP_CNT_EN
        ,
        .io_drop_count (io_drop_count)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: queue of {parity, data} words the FIFO should hold.
    logic [DW:0] exp_q[$];
    logic        exp_ovf = 1'b0;
    int          exp_drops = 0;
    bit          armed = 1'b0;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input int unsigned act, input int unsigned req);
        total_cnt++;
        if (act == req) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, req, $time);
        end
    endtask

    // One bus cycle: drive at negedge, update the model just after the posedge.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic p,
                         input logic r, input logic rst);
        int  sz;
        bit  acc;
        bit  drp;
        @(negedge clk);
        reset       = rst;
        io_x_valid  = v;
        io_x_data   = d;
        io_x_parity = p;
        io_y_ready  = r;
        sz  = exp_q.size();
        acc = !rst && v && ((sz < DEPTH) || (sz > 0 && r));
        drp = !rst && v && !acc;
        @(posedge clk);
        #1;
        if (rst) begin
            exp_q.delete();
            exp_ovf   = 1'b0;
            exp_drops = 0;
        end else begin
            if (acc) exp_q.push_back({p, d});
            exp_ovf = drp;
`ifdef FILTER_SINK_DROP_CNT_EN
            if (drp && exp_drops < DROP_MAX) exp_drops++;
`endif
        end
    endtask

    // Monitor: one time unit before each posedge, compare outputs to the model
    // and retire the head word when the consumer takes it.
    initial begin
        logic [DW:0] head;
        forever begin
            @(negedge clk);
            #4;
            if (armed) begin
                chk("count", io_count, exp_q.size());
                chk("valid", io_y_valid, exp_q.size() != 0);
                chk("overflow", io_overflow, exp_ovf);
`ifdef FILTER_SINK_DROP_CNT_EN
                chk("drop_count", io_drop_count, exp_drops);
`endif
                if (exp_q.size() != 0) begin
                    head = exp_q[0];
                    chk("head_data", io_y_data, head[DW-1:0]);
                    chk("head_parity", io_y_parity, head[DW]);
                    if (io_y_valid && io_y_ready) void'(exp_q.pop_front());
                end else begin
                    chk("empty_data", io_y_data, 0);
                    chk("empty_parity", io_y_parity, 0);
                end
            end
        end
    end

    initial begin
        int sel;
        // Reset, then a single word held for five cycles before being taken.
        cycle(0, '0, 0, 0, 1);
        armed = 1'b1;
        cycle(0, '0, 0, 0, 1);
        cycle(1, 16'h1234, 1, 0, 0);
        repeat (5) cycle(0, '0, 0, 0, 0);
        cycle(0, '0, 0, 1, 0);
        cycle(0, '0, 0, 0, 0);

        // Fill past capacity, then drain.
        for (int i = 1; i <= 5; i++) cycle(1, DW'(i), i[0], 0, 0);
        cycle(0, '0, 0, 0, 0);
        repeat (5) cycle(0, '0, 0, 1, 0);

        // Full FIFO with a simultaneous pop and push.
        for (int i = 0; i < 4; i++) cycle(1, DW'(16'hA000 + i), 0, 0, 0);
        cycle(1, 16'hBEEF, 1, 1, 0);
        repeat (5) cycle(0, '0, 0, 1, 0);

        // Streaming with the consumer always ready; pointers wrap many times.
        for (int i = 0; i < 20; i++) cycle(1, DW'(16'h0100 + i), i[1], 1, 0);
        cycle(0, '0, 0, 1, 0);

        // Reset mid-operation with a valid word on the input.
        for (int i = 0; i < 3; i++) cycle(1, DW'(16'h0C00 + i), 1, 0, 0);
        cycle(1, 16'hDEAD, 1, 0, 1);
        cycle(1, 16'h5A5A, 0, 0, 0);
        cycle(0, '0, 0, 0, 0);
        repeat (2) cycle(0, '0, 0, 1, 0);

        // Sustained drops on a full FIFO (drop counter saturation when built in).
        for (int i = 0; i < 24; i++) cycle(1, DW'($urandom), 1'($urandom), 0, 0);
        repeat (5) cycle(0, '0, 0, 1, 0);

        // Randomized traffic with varying producer/consumer rates.
        for (int i = 0; i < 1500; i++) begin
            sel = i / 250;
            cycle(($urandom_range(0, 7) < 2 + sel),
                  DW'($urandom), 1'($urandom),
                  ($urandom_range(0, 7) < 7 - sel),
                  ($urandom_range(0, 299) == 0));
        end
        repeat (6) cycle(0, '0, 0, 1, 0);

        @(negedge clk);
        #6;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
